// File: rtl/dispatch_unit_pkg.sv
// Shared types and constants for the dispatch stage: type codes, FIFO entry and issue payload.
package dispatch_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ROB_W   = 4;
  localparam int unsigned OPE_W   = 6;
  localparam int unsigned NUM_CDB = 2;
  localparam int unsigned REG_W   = 5;

  // ROB tag 0 is never allocated, so it marks "value already available".
  localparam logic [ROB_W-1:0] NON_DEPENDENT = '0;

  typedef enum logic [OPE_W-1:0] {
    NOP, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } ope_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_jump;
    logic [OPE_W-1:0]  ope;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
  } iq_entry_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_jump;
    logic [OPE_W-1:0]  ope;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [ROB_W-1:0]  qj;
    logic [ROB_W-1:0]  qk;
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] imm;
  } iss_payload_t;

  function automatic logic is_load(input logic [OPE_W-1:0] ope);
    return ope inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input logic [OPE_W-1:0] ope);
    return ope inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Bundle of every dispatch-stage signal except clock and reset; slave = dispatch unit, master = its environment.
interface dispatch_unit_if;
  import dispatch_unit_pkg::*;

  logic                       rdy;
  logic                       flush;

  logic                       in_valid;
  logic                       in_ready;
  logic [ADDR_W-1:0]          in_pc;
  logic [ADDR_W-1:0]          in_pred_pc;
  logic                       in_pred_jump;
  logic [OPE_W-1:0]           in_type;
  logic [REG_W-1:0]           in_rd;
  logic [REG_W-1:0]           in_rs1;
  logic [REG_W-1:0]           in_rs2;
  logic [DATA_W-1:0]          in_imm;

  logic [REG_W-1:0]           rs1_to_reg;
  logic [REG_W-1:0]           rs2_to_reg;
  logic [DATA_W-1:0]          vj_from_reg;
  logic [DATA_W-1:0]          vk_from_reg;
  logic [ROB_W-1:0]           qj_from_reg;
  logic [ROB_W-1:0]           qk_from_reg;

  logic [ROB_W-1:0]           qj_to_rob;
  logic [ROB_W-1:0]           qk_to_rob;
  logic                       qj_ready_from_rob;
  logic                       qk_ready_from_rob;
  logic [DATA_W-1:0]          vj_from_rob;
  logic [DATA_W-1:0]          vk_from_rob;

  logic                       rob_full;
  logic                       rs_full;
  logic                       lsb_full;
  logic [ROB_W-1:0]           rob_alloc_tag;

  logic [NUM_CDB-1:0]         cdb_valid;
  logic [NUM_CDB*ROB_W-1:0]   cdb_tag;
  logic [NUM_CDB*DATA_W-1:0]  cdb_value;

  logic                       rename_en;
  logic [REG_W-1:0]           rename_rd;
  logic [ROB_W-1:0]           rename_tag;

  logic                       rob_en;
  logic                       rs_en;
  logic                       lsb_en;
  logic [ADDR_W-1:0]          iss_pc;
  logic [ADDR_W-1:0]          iss_pred_pc;
  logic                       iss_pred_jump;
  logic [OPE_W-1:0]           iss_type;
  logic [REG_W-1:0]           iss_rd;
  logic [DATA_W-1:0]          iss_vj;
  logic [DATA_W-1:0]          iss_vk;
  logic [ROB_W-1:0]           iss_qj;
  logic [ROB_W-1:0]           iss_qk;
  logic [ROB_W-1:0]           iss_tag;
  logic [DATA_W-1:0]          iss_imm;

  modport slave (
    input  rdy, flush,
    input  in_valid, in_pc, in_pred_pc, in_pred_jump, in_type, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready,
    output rs1_to_reg, rs2_to_reg,
    input  vj_from_reg, vk_from_reg, qj_from_reg, qk_from_reg,
    output qj_to_rob, qk_to_rob,
    input  qj_ready_from_rob, qk_ready_from_rob, vj_from_rob, vk_from_rob,
    input  rob_full, rs_full, lsb_full, rob_alloc_tag,
    input  cdb_valid, cdb_tag, cdb_value,
    output rename_en, rename_rd, rename_tag,
    output rob_en, rs_en, lsb_en,
    output iss_pc, iss_pred_pc, iss_pred_jump, iss_type, iss_rd,
    output iss_vj, iss_vk, iss_qj, iss_qk, iss_tag, iss_imm
  );

  modport master (
    output rdy, flush,
    output in_valid, in_pc, in_pred_pc, in_pred_jump, in_type, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready,
    input  rs1_to_reg, rs2_to_reg,
    output vj_from_reg, vk_from_reg, qj_from_reg, qk_from_reg,
    input  qj_to_rob, qk_to_rob,
    output qj_ready_from_rob, qk_ready_from_rob, vj_from_rob, vk_from_rob,
    output rob_full, rs_full, lsb_full, rob_alloc_tag,
    output cdb_valid, cdb_tag, cdb_value,
    input  rename_en, rename_rd, rename_tag,
    input  rob_en, rs_en, lsb_en,
    input  iss_pc, iss_pred_pc, iss_pred_jump, iss_type, iss_rd,
    input  iss_vj, iss_vk, iss_qj, iss_qk, iss_tag, iss_imm
  );

endinterface

// File: rtl/dispatch_unit_operand_resolver.sv
// Resolves one source operand to (value, tag) from register file, CDB broadcasts and ROB, in that priority.
module dispatch_unit_operand_resolver
  import dispatch_unit_pkg::*;
(
  input  logic [REG_W-1:0]          i_src,
  input  logic [ROB_W-1:0]          i_q_from_reg,
  input  logic [DATA_W-1:0]         i_v_from_reg,
  input  logic                      i_q_ready_from_rob,
  input  logic [DATA_W-1:0]         i_v_from_rob,
  input  logic [NUM_CDB-1:0]        i_cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  i_cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] i_cdb_value,
  output logic [DATA_W-1:0]         o_v_c,
  output logic [ROB_W-1:0]          o_q_c
);

  logic              w_cdb_hit;
  logic [DATA_W-1:0] w_cdb_value;

  // Scan from the top channel down so the lowest matching index overrides.
  always_comb begin : cdb_match
    w_cdb_hit   = 1'b0;
    w_cdb_value = '0;
    for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
      if (i_cdb_valid[i] && (i_cdb_tag[i*ROB_W +: ROB_W] == i_q_from_reg)) begin
        w_cdb_hit   = 1'b1;
        w_cdb_value = i_cdb_value[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : resolve
    o_v_c = '0;
    o_q_c = NON_DEPENDENT;
    if (i_src == '0) begin
      o_v_c = '0;
    end else if (i_q_from_reg == NON_DEPENDENT) begin
      o_v_c = i_v_from_reg;
    end else if (w_cdb_hit) begin
      o_v_c = w_cdb_value;
    end else if (i_q_ready_from_rob) begin
      o_v_c = i_v_from_rob;
    end else begin
      o_q_c = i_q_from_reg;
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch stage: decoded-instruction FIFO, operand resolution, ROB allocation and RS/LSB issue.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  dispatch_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t          r_mem [IQ_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_rob_en;
  logic               r_rs_en;
  logic               r_lsb_en;
  iss_payload_t       r_iss;

  iq_entry_t          w_in;
  iq_entry_t          w_head;
  iss_payload_t       w_iss;
  logic               w_in_ready;
  logic               w_push;
  logic               w_issue;
  logic               w_to_lsb;
  logic               w_unit_full;
  logic [DATA_W-1:0]  w_vj;
  logic [DATA_W-1:0]  w_vk;
  logic [ROB_W-1:0]   w_qj;
  logic [ROB_W-1:0]   w_qk;

  assign w_in = '{
    pc:        bus.in_pc,
    pred_pc:   bus.in_pred_pc,
    pred_jump: bus.in_pred_jump,
    ope:       bus.in_type,
    rd:        bus.in_rd,
    rs1:       bus.in_rs1,
    rs2:       bus.in_rs2,
    imm:       bus.in_imm
  };
  assign w_head = r_mem[r_rptr];

  // No full-FIFO bypass: readiness depends only on the current occupancy.
  assign w_in_ready  = bus.rdy && !bus.flush && (r_count < CNT_W'(IQ_DEPTH));
  assign w_push      = !rst && bus.in_valid && w_in_ready;
  assign w_to_lsb    = is_load(w_head.ope) || is_store(w_head.ope);
  assign w_unit_full = w_to_lsb ? bus.lsb_full : bus.rs_full;
  assign w_issue     = !rst && bus.rdy && !bus.flush && (r_count != '0)
                       && !bus.rob_full && !w_unit_full;

  dispatch_unit_operand_resolver u_res_j (
    .i_src              (w_head.rs1),
    .i_q_from_reg       (bus.qj_from_reg),
    .i_v_from_reg       (bus.vj_from_reg),
    .i_q_ready_from_rob (bus.qj_ready_from_rob),
    .i_v_from_rob       (bus.vj_from_rob),
    .i_cdb_valid        (bus.cdb_valid),
    .i_cdb_tag          (bus.cdb_tag),
    .i_cdb_value        (bus.cdb_value),
    .o_v_c              (w_vj),
    .o_q_c              (w_qj)
  );

  dispatch_unit_operand_resolver u_res_k (
    .i_src              (w_head.rs2),
    .i_q_from_reg       (bus.qk_from_reg),
    .i_v_from_reg       (bus.vk_from_reg),
    .i_q_ready_from_rob (bus.qk_ready_from_rob),
    .i_v_from_rob       (bus.vk_from_rob),
    .i_cdb_valid        (bus.cdb_valid),
    .i_cdb_tag          (bus.cdb_tag),
    .i_cdb_value        (bus.cdb_value),
    .o_v_c              (w_vk),
    .o_q_c              (w_qk)
  );

  assign w_iss = '{
    pc:        w_head.pc,
    pred_pc:   w_head.pred_pc,
    pred_jump: w_head.pred_jump,
    ope:       w_head.ope,
    rd:        w_head.rd,
    vj:        w_vj,
    vk:        w_vk,
    qj:        w_qj,
    qk:        w_qk,
    tag:       bus.rob_alloc_tag,
    imm:       w_head.imm
  };

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin : fifo_mem
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  always_ff @(posedge clk) begin : ctrl
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rob_en <= 1'b0;
      r_rs_en  <= 1'b0;
      r_lsb_en <= 1'b0;
      r_iss    <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_count  <= '0;
        r_rob_en <= 1'b0;
        r_rs_en  <= 1'b0;
        r_lsb_en <= 1'b0;
        r_iss    <= '0;
      end else begin
        r_rob_en <= w_issue;
        r_rs_en  <= w_issue && !w_to_lsb;
        r_lsb_en <= w_issue && w_to_lsb;
        if (w_push) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_issue) begin
          r_rptr <= r_rptr + PTR_W'(1);
          r_iss  <= w_iss;
        end
        case ({w_push, w_issue})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.rs1_to_reg = w_head.rs1;
  assign bus.rs2_to_reg = w_head.rs2;
  assign bus.qj_to_rob  = bus.qj_from_reg;
  assign bus.qk_to_rob  = bus.qk_from_reg;

  // Register file commits the rename on the issuing edge.
  assign bus.rename_en  = w_issue && (w_head.rd != '0);
  assign bus.rename_rd  = w_head.rd;
  assign bus.rename_tag = bus.rob_alloc_tag;

  assign bus.rob_en        = r_rob_en;
  assign bus.rs_en         = r_rs_en;
  assign bus.lsb_en        = r_lsb_en;
  assign bus.iss_pc        = r_iss.pc;
  assign bus.iss_pred_pc   = r_iss.pred_pc;
  assign bus.iss_pred_jump = r_iss.pred_jump;
  assign bus.iss_type      = r_iss.ope;
  assign bus.iss_rd        = r_iss.rd;
  assign bus.iss_vj        = r_iss.vj;
  assign bus.iss_vk        = r_iss.vk;
  assign bus.iss_qj        = r_iss.qj;
  assign bus.iss_qk        = r_iss.qk;
  assign bus.iss_tag       = r_iss.tag;
  assign bus.iss_imm       = r_iss.imm;

endmodule
